param_sync_fifo: RTL

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ram.sv | 21 ++
 rtl/param_sync_fifo.sv | 106 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and the address-width helper for the synchronous FIFO family.
package fifo_pkg;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 16;

  // Smallest r with 2**r >= n; used to size RAM addresses.
  function automatic int unsigned fifo_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// DATA_W x DEPTH storage: synchronous write, asynchronous read, contents never reset.
module fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy/threshold flags and overflow/underflow pulses.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 2,
  localparam int unsigned AW    = fifo_log2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] iData,
  output logic [DATA_W-1:0] oData,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [AW:0] AF_C = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_C = (AW+1)'(AE_LVL);

  logic [AW:0]       wp_q, wp_d, rp_q, rp_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              wr_acc, rd_acc, ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty        = (wp_q == rp_q);
  assign full         = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign count        = wp_q - rp_q;
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = write && !full;
  assign rd_acc = read && !empty;
  assign ram_we = wr_acc && !clear;

  always_comb begin
    wp_d  = wp_q + {{AW{1'b0}}, wr_acc};
    rp_d  = rp_q + {{AW{1'b0}}, rd_acc};
    ovf_d = write && full;
    unf_d = read && empty;
    if (clear) begin
      wp_d  = '0;
      rp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (wp_q[AW-1:0]),
    .wdata_i (iData),
    .raddr_i (rp_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  assign oData = ram_rdata;
`else
  logic [DATA_W-1:0] odata_q, odata_d;

  always_comb begin
    odata_d = odata_q;
    if (clear)       odata_d = '0;
    else if (rd_acc) odata_d = ram_rdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) odata_q <= '0;
    else     odata_q <= odata_d;
  end

  assign oData = odata_q;
`endif
endmodule
